// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: bus-facing controller for the UART receiver.
// Holds the receiver configuration and applies it only between frames.
// Buffers received bytes in a FIFO and keeps sticky error/overrun flags.
// Raises a registered level interrupt.
module uart_rx_ctrl #(
  parameter int FIFO_AW = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Sel,
  input  logic        Wr,
  input  logic [1:0]  Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Irq,
  output logic [2:0]  DataLenLimit,
  output logic        StopLenLimit,
  output logic        ParityEn,
  output logic        ParityPolarity,
  output logic [13:0] BaudLimit,
  output logic        Enable,
  input  logic        RxReady,
  input  logic [7:0]  RxData,
  input  logic        RxParityErr,
  input  logic        RxFrameErr,
  input  logic        RxBusy
);

  localparam int Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] OneCnt   = {{FIFO_AW{1'b0}}, 1'b1};
  // BaudLimit 1562, Data8=1, everything else off
  localparam logic [19:0] CtrlResetVal = 20'h0461A;

  logic [19:0]        ctrlShadow;
  logic               cfgPending;
  logic [7:0]         fifoMem [Depth];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   thresh;
  logic               ovrFlag;
  logic               parFlag;
  logic               frmFlag;

  logic fifoEmpty, fifoFull;
  logic ctrlWr, statWr, threshWr, dataRd;
  logic flush, pop, push, dropByte, applyCfg;
  logic unusedWrData;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == DepthCnt);

  assign ctrlWr   = Sel & Wr & (Addr == 2'd0);
  assign statWr   = Sel & Wr & (Addr == 2'd1);
  assign threshWr = Sel & Wr & (Addr == 2'd3);
  assign dataRd   = Sel & ~Wr & (Addr == 2'd2);

  // Flush beats a same-cycle push: the byte is discarded and not counted as overrun.
  assign flush    = statWr & WrData[31];
  assign pop      = dataRd & ~fifoEmpty;
  assign push     = RxReady & (~fifoFull | pop) & ~flush;
  assign dropByte = RxReady & fifoFull & ~pop & ~flush;
  assign applyCfg = cfgPending & ~RxBusy;

  // Enable and IrqEn act straight from the shadow, independent of frame state.
  assign Enable = ctrlShadow[18];

  assign unusedWrData = &{1'b0, WrData[30:20]};

  // Shadow configuration register and its pending-apply flag
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ctrlShadow <= CtrlResetVal;
      cfgPending <= 1'b0;
    end else begin
      if (ctrlWr) ctrlShadow <= WrData[19:0];
      // a write colliding with an apply keeps pending so the new value lands next idle cycle
      cfgPending <= ctrlWr | (cfgPending & ~applyCfg);
    end
  end

  // Applied receiver configuration, frozen while a frame is in progress
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      BaudLimit      <= CtrlResetVal[13:0];
      DataLenLimit   <= 3'd7;
      StopLenLimit   <= 1'b0;
      ParityEn       <= 1'b0;
      ParityPolarity <= 1'b0;
    end else if (applyCfg) begin
      BaudLimit      <= ctrlShadow[13:0];
      DataLenLimit   <= ctrlShadow[14] ? 3'd7 : 3'd6;
      StopLenLimit   <= ctrlShadow[15];
      ParityEn       <= ctrlShadow[16];
      ParityPolarity <= ctrlShadow[17];
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + OneCnt;
        2'b01:   count <= count - OneCnt;
        default: count <= count;
      endcase
    end
  end

  // FIFO byte storage
  always_ff @(posedge Clock) begin
    if (push) fifoMem[wrPtr] <= RxData;
  end

  // Sticky flags; a new event in the same cycle as a clear keeps the flag set
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ovrFlag <= 1'b0;
      parFlag <= 1'b0;
      frmFlag <= 1'b0;
    end else begin
      ovrFlag <= dropByte    | (ovrFlag & ~(statWr & WrData[10]));
      parFlag <= RxParityErr | (parFlag & ~(statWr & WrData[11]));
      frmFlag <= RxFrameErr  | (frmFlag & ~(statWr & WrData[12]));
    end
  end

  // Interrupt threshold; zero is meaningless so it is stored as one
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      thresh <= OneCnt;
    end else if (threshWr) begin
      thresh <= (WrData[FIFO_AW:0] == '0) ? OneCnt : WrData[FIFO_AW:0];
    end
  end

  // Registered level interrupt
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Irq <= 1'b0;
    end else begin
      Irq <= ctrlShadow[19] & ((count >= thresh) | ovrFlag | parFlag | frmFlag);
    end
  end

  // Read mux, combinational from Addr
  always_comb begin
    RdData = '0;
    case (Addr)
      2'd0: RdData[19:0] = ctrlShadow;
      2'd1: begin
        RdData[FIFO_AW:0] = count;
        RdData[8]         = fifoEmpty;
        RdData[9]         = fifoFull;
        RdData[10]        = ovrFlag;
        RdData[11]        = parFlag;
        RdData[12]        = frmFlag;
        RdData[13]        = cfgPending;
        RdData[14]        = RxBusy;
      end
      2'd2: begin
        if (!fifoEmpty) RdData[8:0] = {1'b1, fifoMem[rdPtr]};
      end
      default: RdData[FIFO_AW:0] = thresh;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Sel = 1'b0;
  logic        Wr = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic [31:0] WrData = '0;
  logic [31:0] RdData;
  logic        Irq;
  logic [2:0]  DataLenLimit;
  logic        StopLenLimit;
  logic        ParityEn;
  logic        ParityPolarity;
  logic [13:0] BaudLimit;
  logic        Enable;
  logic        RxReady = 1'b0;
  logic [7:0]  RxData = '0;
  logic        RxParityErr = 1'b0;
  logic        RxFrameErr = 1'b0;
  logic        RxBusy = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] rd;

  uart_rx_ctrl #(.FIFO_AW(3)) dut (
    .Clock(Clock), .Reset(Reset), .Sel(Sel), .Wr(Wr), .Addr(Addr),
    .WrData(WrData), .RdData(RdData), .Irq(Irq),
    .DataLenLimit(DataLenLimit), .StopLenLimit(StopLenLimit),
    .ParityEn(ParityEn), .ParityPolarity(ParityPolarity),
    .BaudLimit(BaudLimit), .Enable(Enable),
    .RxReady(RxReady), .RxData(RxData), .RxParityErr(RxParityErr),
    .RxFrameErr(RxFrameErr), .RxBusy(RxBusy)
  );

  always #5 Clock = ~Clock;

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b1; Addr = a; WrData = d;
    @(negedge Clock);
    Sel = 1'b0; Wr = 1'b0; WrData = '0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b0; Addr = a;
    #1 d = RdData;
    @(negedge Clock);
    Sel = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] b);
    @(negedge Clock);
    RxReady = 1'b1; RxData = b;
    @(negedge Clock);
    RxReady = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    busRead(2'd0, rd);
    checks++; if (rd !== 32'h0000_461A) begin failures++; $display("FAIL ctrl_reset got=%h exp=%h", rd, 32'h0000_461A); end
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL status_reset got=%h exp=%h", rd, 32'h0000_0100); end
    busRead(2'd3, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL thresh_reset got=%h exp=%h", rd, 32'd1); end
    checks++; if ({Irq, Enable} !== 2'b00) begin failures++; $display("FAIL irq_en_reset got=%b exp=%b", {Irq, Enable}, 2'b00); end
    checks++; if ({BaudLimit, DataLenLimit} !== {14'd1562, 3'd7}) begin failures++; $display("FAIL cfg_reset got=%0d/%0d exp=1562/7", BaudLimit, DataLenLimit); end
  endtask

  task automatic test_cfg_apply;
    RxBusy = 1'b1;
    busWrite(2'd0, 32'h0004_4000 | 32'd129);
    #1;
    checks++; if (BaudLimit !== 14'd1562) begin failures++; $display("FAIL baud_hold_busy got=%0d exp=1562", BaudLimit); end
    checks++; if (Enable !== 1'b1) begin failures++; $display("FAIL enable_while_busy got=%b exp=1", Enable); end
    Addr = 2'd1;
    repeat (3) @(negedge Clock);
    #1;
    checks++; if ({RdData[13], BaudLimit} !== {1'b1, 14'd1562}) begin failures++; $display("FAIL pending_busy got=%b/%0d exp=1/1562", RdData[13], BaudLimit); end
    RxBusy = 1'b0;
    @(negedge Clock);
    #1;
    checks++; if ({RdData[13], BaudLimit} !== {1'b0, 14'd129}) begin failures++; $display("FAIL apply_idle got=%b/%0d exp=0/129", RdData[13], BaudLimit); end
    // back-to-back CTRL writes: second write collides with the apply of the first
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b1; Addr = 2'd0; WrData = 32'h0004_4000 | 32'd300;
    @(negedge Clock);
    WrData = 32'h0007_8000 | 32'd400;
    @(negedge Clock);
    Sel = 1'b0; Wr = 1'b0; WrData = '0; Addr = 2'd1;
    #1;
    checks++; if ({RdData[13], BaudLimit} !== {1'b1, 14'd300}) begin failures++; $display("FAIL collide_apply got=%b/%0d exp=1/300", RdData[13], BaudLimit); end
    @(negedge Clock);
    #1;
    checks++; if ({RdData[13], BaudLimit} !== {1'b0, 14'd400}) begin failures++; $display("FAIL collide_next got=%b/%0d exp=0/400", RdData[13], BaudLimit); end
    checks++; if ({DataLenLimit, StopLenLimit, ParityEn, ParityPolarity} !== {3'd6, 3'b111}) begin failures++; $display("FAIL cfg_fields got=%b exp=%b", {DataLenLimit, StopLenLimit, ParityEn, ParityPolarity}, {3'd6, 3'b111}); end
  endtask

  task automatic test_fifo_order;
    pushByte(8'h41); pushByte(8'h42); pushByte(8'h43);
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0003) begin failures++; $display("FAIL count3 got=%h exp=%h", rd, 32'h3); end
    for (int i = 0; i < 3; i++) begin
      busRead(2'd2, rd);
      checks++; if (rd !== 32'h141 + i) begin failures++; $display("FAIL fifo_order%0d got=%h exp=%h", i, rd, 32'h141 + i); end
    end
    busRead(2'd2, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL read_empty got=%h exp=0", rd); end
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL empty_after_pop got=%h exp=%h", rd, 32'h100); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 9; i++) pushByte(8'h10 + 8'(i));
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0608) begin failures++; $display("FAIL full_ovr got=%h exp=%h", rd, 32'h608); end
    busWrite(2'd1, 32'h0000_0400);
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0208) begin failures++; $display("FAIL ovr_w1c got=%h exp=%h", rd, 32'h208); end
    // overrun event coinciding with its clear
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b1; Addr = 2'd1; WrData = 32'h0000_0400; RxReady = 1'b1; RxData = 8'hEE;
    @(negedge Clock);
    Sel = 1'b0; Wr = 1'b0; WrData = '0; RxReady = 1'b0;
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0608) begin failures++; $display("FAIL ovr_set_wins got=%h exp=%h", rd, 32'h608); end
    busWrite(2'd1, 32'h0000_0400);
    // pop and push on a full FIFO in the same cycle
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b0; Addr = 2'd2; RxReady = 1'b1; RxData = 8'h99;
    #1 rd = RdData;
    @(negedge Clock);
    Sel = 1'b0; RxReady = 1'b0;
    checks++; if (rd !== 32'h110) begin failures++; $display("FAIL full_pop got=%h exp=%h", rd, 32'h110); end
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0208) begin failures++; $display("FAIL full_pushpop got=%h exp=%h", rd, 32'h208); end
    for (int i = 0; i < 8; i++) begin
      busRead(2'd2, rd);
      checks++;
      if (rd !== ((i < 7) ? 32'h111 + i : 32'h199)) begin
        failures++; $display("FAIL drain%0d got=%h exp=%h", i, rd, (i < 7) ? 32'h111 + i : 32'h199);
      end
    end
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL drained got=%h exp=%h", rd, 32'h100); end
  endtask

  task automatic test_irq;
    busWrite(2'd0, 32'h000C_461A);
    busWrite(2'd3, 32'd0);
    busRead(2'd3, rd);
    checks++; if (rd !== 32'd1) begin failures++; $display("FAIL thresh_zero got=%h exp=1", rd); end
    busWrite(2'd3, 32'd2);
    busRead(2'd3, rd);
    checks++; if (rd !== 32'd2) begin failures++; $display("FAIL thresh_rw got=%h exp=2", rd); end
    pushByte(8'h55);
    repeat (2) @(negedge Clock);
    checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", Irq); end
    pushByte(8'h56);
    #1;
    checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_latency got=%b exp=0", Irq); end
    @(negedge Clock); #1;
    checks++; if (Irq !== 1'b1) begin failures++; $display("FAIL irq_thresh got=%b exp=1", Irq); end
    busRead(2'd2, rd);
    #1;
    checks++; if (Irq !== 1'b1) begin failures++; $display("FAIL irq_pop_hold got=%b exp=1", Irq); end
    @(negedge Clock); #1;
    checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_pop_drop got=%b exp=0", Irq); end
  endtask

  task automatic test_frame_flush;
    @(negedge Clock); RxFrameErr = 1'b1;
    @(negedge Clock); RxFrameErr = 1'b0;
    #1;
    checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_frame_early got=%b exp=0", Irq); end
    @(negedge Clock); #1;
    checks++; if (Irq !== 1'b1) begin failures++; $display("FAIL irq_frame got=%b exp=1", Irq); end
    @(negedge Clock); RxParityErr = 1'b1;
    @(negedge Clock); RxParityErr = 1'b0;
    // flush with a simultaneous byte arrival
    @(negedge Clock);
    Sel = 1'b1; Wr = 1'b1; Addr = 2'd1; WrData = 32'h8000_0000; RxReady = 1'b1; RxData = 8'h77;
    @(negedge Clock);
    Sel = 1'b0; Wr = 1'b0; WrData = '0; RxReady = 1'b0;
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_1900) begin failures++; $display("FAIL flush_push got=%h exp=%h", rd, 32'h1900); end
    busRead(2'd2, rd);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", rd); end
    busWrite(2'd1, 32'h0000_1800);
    @(negedge Clock); #1;
    checks++; if (Irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%b exp=0", Irq); end
    busRead(2'd1, rd);
    checks++; if (rd !== 32'h0000_0100) begin failures++; $display("FAIL flags_cleared got=%h exp=%h", rd, 32'h100); end
  endtask

  task automatic test_reset_midframe;
    RxBusy = 1'b1;
    pushByte(8'hA5);
    busWrite(2'd0, 32'h0004_0100);
    @(negedge Clock);
    Reset = 1'b0; Addr = 2'd1;
    #1;
    checks++; if (RdData !== 32'h0000_4100) begin failures++; $display("FAIL midframe_status got=%h exp=%h", RdData, 32'h4100); end
    checks++; if ({Enable, Irq, BaudLimit} !== {2'b00, 14'd1562}) begin failures++; $display("FAIL midframe_cfg got=%b%b/%0d exp=00/1562", Enable, Irq, BaudLimit); end
    @(negedge Clock);
    RxBusy = 1'b0; Reset = 1'b1;
  endtask

  initial begin
    test_reset;
    test_cfg_apply;
    test_fifo_order;
    test_overrun;
    test_irq;
    test_frame_flush;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
